// File: rtl/fastserial_tx_arb_pkg.sv
// Shared definitions for the fast-serial TX arbiter: state encodings,
// the default header tag and the header byte field layout.
package fastserial_defs;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_DATA    = 2'd2,
    ST_TRAILER = 2'd3
  } state_t;

  localparam logic [3:0]  HDR_TAG_DEFAULT = 4'hA;
  localparam int unsigned HDR_CONT_BIT    = 3;
  localparam int unsigned IDX_W           = 3;

  // Header byte: tag in the upper nibble, continuation flag, source index.
  function automatic logic [7:0] make_hdr(input logic [3:0]       tag,
                                          input logic             cont,
                                          input logic [IDX_W-1:0] idx);
    logic [7:0] h;
    h               = {tag, 4'h0};
    h[HDR_CONT_BIT] = cont;
    h[IDX_W-1:0]    = idx;
    return h;
  endfunction

endpackage

// File: rtl/fastserial_tx_arb_rr_pick.sv
// Combinational round-robin pick: first request at or after ptr, wrapping.
module fs_rr_pick
  import fastserial_defs::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   index,
  output logic               any
);

  localparam int unsigned PW = IDX_W + 1;

  logic [NUM_REQ-1:0] rot;
  logic [PW-1:0]      pos;

  // Rotate so bit 0 is the pointer position, then take the lowest set bit.
  always_comb begin
    rot   = NUM_REQ'({req, req} >> ptr);
    grant = '0;
    index = '0;
    any   = 1'b0;
    pos   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!any && rot[i]) begin
        any = 1'b1;
        pos = {1'b0, ptr} + PW'(i);
        if (pos >= PW'(NUM_REQ)) pos = pos - PW'(NUM_REQ);
        index = pos[IDX_W-1:0];
        grant = NUM_REQ'(1) << pos;
      end
    end
  end

endmodule

// File: rtl/fastserial_tx_arb.sv
// Packet-level round-robin arbiter onto the fast-serial TX FIFO write port.
// Optional per-grant XOR trailer byte: define FS_ARB_CHKSUM_EN.
module fastserial_tx_arb
  import fastserial_defs::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned MAX_PKT_LEN  = 64,
  parameter int unsigned IDLE_TIMEOUT = 255,
  parameter logic [3:0]  HDR_TAG      = HDR_TAG_DEFAULT
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [NUM_REQ*8-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]   i_req_last,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_write,
  input  logic                 i_tx_full,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic                 o_busy
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   g_q, ptr_q, ptr_next;
  logic [NUM_REQ-1:0] grant_q, cont_q;
  logic [7:0]         cnt_q, tmo_q;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  logic               sel_valid, sel_last, sel_cont;
  logic [7:0]         sel_data, hdr;
  logic               grab, hdr_wr, xfer, tmo_tick, rel, rel_cont;
  logic               len_hit, tmo_hit;

`ifdef FS_ARB_CHKSUM_EN
  logic [7:0]         csum_q;
`endif

  fs_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (i_req_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .index (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_cont  = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (g_q == IDX_W'(i)) begin
        sel_valid = i_req_valid[i];
        sel_last  = i_req_last[i];
        sel_cont  = cont_q[i];
        sel_data  = i_req_data[8*i +: 8];
      end
    end
  end

  assign hdr      = make_hdr(HDR_TAG, sel_cont, g_q);
  assign len_hit  = (cnt_q == 8'(MAX_PKT_LEN - 1));
  assign tmo_hit  = (tmo_q == 8'(IDLE_TIMEOUT - 1));
  assign ptr_next = (g_q == IDX_W'(NUM_REQ - 1)) ? '0 : g_q + 1'b1;
  assign o_grant  = grant_q;
  assign o_busy   = (state_q != ST_IDLE);

  always_comb begin
    state_d     = state_q;
    o_tx_write  = 1'b0;
    o_tx_data   = '0;
    o_req_ready = '0;
    grab        = 1'b0;
    hdr_wr      = 1'b0;
    xfer        = 1'b0;
    tmo_tick    = 1'b0;
    rel         = 1'b0;
    rel_cont    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grab    = 1'b1;
          state_d = ST_HEADER;
        end
      end
      ST_HEADER: begin
        if (!i_tx_full) begin
          o_tx_write = 1'b1;
          o_tx_data  = hdr;
          hdr_wr     = 1'b1;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (!i_tx_full) begin
          o_req_ready = grant_q;
          if (sel_valid) begin
            o_tx_write = 1'b1;
            o_tx_data  = sel_data;
            xfer       = 1'b1;
            // last takes priority over the length limit, leaving cont clear
            if (sel_last) begin
              rel = 1'b1;
            end else if (len_hit) begin
              rel      = 1'b1;
              rel_cont = 1'b1;
            end
          end else if (tmo_hit) begin
            rel      = 1'b1;
            rel_cont = 1'b1;
          end else begin
            tmo_tick = 1'b1;
          end
        end
        if (rel) begin
`ifdef FS_ARB_CHKSUM_EN
          state_d = ST_TRAILER;
`else
          state_d = ST_IDLE;
`endif
        end
      end
`ifdef FS_ARB_CHKSUM_EN
      ST_TRAILER: begin
        if (!i_tx_full) begin
          o_tx_write = 1'b1;
          o_tx_data  = csum_q;
          state_d    = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      g_q     <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      cont_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      if (grab) begin
        g_q     <= pick_idx;
        grant_q <= pick_grant;
      end
      if (hdr_wr) begin
        cont_q <= cont_q & ~grant_q;
        cnt_q  <= '0;
        tmo_q  <= '0;
      end
      if (xfer) begin
        cnt_q <= cnt_q + 8'd1;
        tmo_q <= '0;
      end
      if (tmo_tick) tmo_q <= tmo_q + 8'd1;
      if (rel) begin
        grant_q <= '0;
        ptr_q   <= ptr_next;
        tmo_q   <= '0;
        if (rel_cont) cont_q <= cont_q | grant_q;
      end
    end
  end

`ifdef FS_ARB_CHKSUM_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    csum_q <= '0;
    else if (grab)   csum_q <= '0;
    else if (hdr_wr) csum_q <= csum_q ^ hdr;
    else if (xfer)   csum_q <= csum_q ^ sel_data;
  end
`endif

endmodule
